// File: rtl/bp_stage.sv
// bp_stage: next-PC predictor (direct-mapped BTB + gshare PHT) with
// AGEX-driven training and misprediction flush toward fetch.
module bp_stage #(
   parameter int          DBITS        = 32,
   parameter int          BTB_IDX_BITS = 4,
   parameter int          GHR_BITS     = 8,
   parameter logic [31:0] STARTPC      = 32'h100
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DBITS-1:0] fe_pc,
   input  logic             agex_valid,
   input  logic             agex_is_branch,
   input  logic             agex_taken,
   input  logic [DBITS-1:0] agex_pc,
   input  logic [DBITS-1:0] agex_target,
   input  logic [DBITS-1:0] agex_pred_npc,
   output logic [DBITS:0]   from_BP_to_FE,
   output logic [31:0]      bp_branch_cnt,
   output logic [31:0]      bp_mispred_cnt
);
   localparam int TAG_W = DBITS - BTB_IDX_BITS - 2;
   localparam int BTB_N = 1 << BTB_IDX_BITS;
   localparam int PHT_N = 1 << GHR_BITS;

   logic [BTB_N-1:0]        btb_valid_q, btb_valid_d;
   logic [TAG_W-1:0]        btb_tag_q [BTB_N];
   logic [TAG_W-1:0]        btb_tag_d [BTB_N];
   logic [DBITS-1:0]        btb_tgt_q [BTB_N];
   logic [DBITS-1:0]        btb_tgt_d [BTB_N];
   logic [1:0]              pht_q [PHT_N];
   logic [1:0]              pht_d [PHT_N];
   logic [GHR_BITS-1:0]     ghr_q, ghr_d;
   logic [31:0]             br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;

   logic [BTB_IDX_BITS-1:0] fe_bidx, ag_bidx;
   logic [GHR_BITS-1:0]     fe_pidx, ag_pidx;
   logic                    btb_hit, pred_taken, resolve, mispredict;
   logic [DBITS-1:0]        pred_npc, actual_npc;
   logic [1:0]              ctr;
   logic                    unused_startpc;

   assign unused_startpc = ^STARTPC;

   assign fe_bidx    = fe_pc[BTB_IDX_BITS+1:2];
   assign fe_pidx    = fe_pc[GHR_BITS+1:2] ^ ghr_q;
   assign btb_hit    = btb_valid_q[fe_bidx] && (btb_tag_q[fe_bidx] == fe_pc[DBITS-1:BTB_IDX_BITS+2]);
   assign pred_taken = btb_hit && pht_q[fe_pidx][1];
   assign pred_npc   = pred_taken ? btb_tgt_q[fe_bidx] : fe_pc + DBITS'(4);

   assign ag_bidx    = agex_pc[BTB_IDX_BITS+1:2];
   assign ag_pidx    = agex_pc[GHR_BITS+1:2] ^ ghr_q;
   assign resolve    = agex_valid && agex_is_branch;
   assign actual_npc = agex_taken ? agex_target : agex_pc + DBITS'(4);
   assign mispredict = resolve && (actual_npc != agex_pred_npc);
   assign ctr        = pht_q[ag_pidx];

   assign from_BP_to_FE  = mispredict ? {1'b1, actual_npc} : {1'b0, pred_npc};
   assign bp_branch_cnt  = br_cnt_q;
   assign bp_mispred_cnt = mp_cnt_q;

   always_comb begin
      btb_valid_d = btb_valid_q;
      btb_tag_d   = btb_tag_q;
      btb_tgt_d   = btb_tgt_q;
      pht_d       = pht_q;
      ghr_d       = resolve ? {ghr_q[GHR_BITS-2:0], agex_taken} : ghr_q;
      br_cnt_d    = br_cnt_q + {31'd0, resolve};
      mp_cnt_d    = mp_cnt_q + {31'd0, mispredict};
      if (resolve) begin
         pht_d[ag_pidx] = agex_taken ? ((ctr == 2'd3) ? 2'd3 : ctr + 2'd1)
                                     : ((ctr == 2'd0) ? 2'd0 : ctr - 2'd1);
         // Only taken outcomes allocate; not-taken entries would never redirect fetch.
         if (agex_taken) begin
            btb_valid_d[ag_bidx] = 1'b1;
            btb_tag_d[ag_bidx]   = agex_pc[DBITS-1:BTB_IDX_BITS+2];
            btb_tgt_d[ag_bidx]   = agex_target;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         btb_valid_q <= '0;
         pht_q       <= '{default: 2'b01};
         ghr_q       <= '0;
         br_cnt_q    <= '0;
         mp_cnt_q    <= '0;
      end else begin
         btb_valid_q <= btb_valid_d;
         btb_tag_q   <= btb_tag_d;
         btb_tgt_q   <= btb_tgt_d;
         pht_q       <= pht_d;
         ghr_q       <= ghr_d;
         br_cnt_q    <= br_cnt_d;
         mp_cnt_q    <= mp_cnt_d;
      end
   end
endmodule

// File: doc/bp_stage.md
# bp_stage

Next-PC generator that sits directly upstream of the fetch stage. Each cycle it takes the fetch PC and returns the predicted next PC and a flush flag, packed as {flush, next_pc}. It uses a direct-mapped BTB and a gshare pattern history table (PHT) of 2-bit counters. AGEX resolves branches and sends the outcome back here; on a misprediction the block steers fetch to the corrected PC and raises flush for that cycle.

## Interface
- DBITS, 32: PC/data width.
- BTB_IDX_BITS, 4: log2 of BTB entries (16).
- GHR_BITS, 8: global history length; the PHT has 2^GHR_BITS entries.
- STARTPC, 32'h100: documentation only; the fetch stage owns the reset PC.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- fe_pc  in  DBITS  PC currently held in the fetch PC latch.
- agex_valid  in  1  AGEX holds a valid, non-flushed instruction.
- agex_is_branch  in  1  the instruction is a conditional branch or jump.
- agex_taken  in  1  resolved direction.
- agex_pc  in  DBITS  PC of the resolving instruction.
- agex_target  in  DBITS  resolved taken target.
- agex_pred_npc  in  DBITS  next PC predicted for this instruction, carried down the pipeline.
- from_BP_to_FE  out  1+DBITS  {flush, next_pc}.
- bp_branch_cnt  out  32  resolved branches since reset.
- bp_mispred_cnt  out  32  mispredictions since reset.

## Operation
- PC word index: pc[BTB_IDX_BITS+1:2].
- BTB entry fields: valid, tag = pc[DBITS-1:BTB_IDX_BITS+2], target.
- PHT index: pc[GHR_BITS+1:2] XOR ghr.
- Lookup is combinational on fe_pc.
  - btb_hit = valid && tag match.
  - pred_taken = btb_hit && pht[idx] >= 2.
  - pred_npc = pred_taken ? btb target : fe_pc + 4, modulo 2^DBITS.
- Resolution applies when agex_valid && agex_is_branch:
  - actual_npc = agex_taken ? agex_target : agex_pc + 4.
  - mispredict = (actual_npc != agex_pred_npc).
- Output mux:
  - mispredict: from_BP_to_FE = {1, actual_npc}.
  - otherwise: {0, pred_npc}.
- Updates at posedge, on resolution only:
  - PHT[agex_pc index XOR current ghr]: taken increments, saturating at 3; not-taken decrements, saturating at 0.
  - ghr <= {ghr[GHR_BITS-2:0], agex_taken}. History is non-speculative; indexing with the update-time ghr is the intended approximation.
  - BTB: taken writes valid=1, tag, target. Not-taken leaves the BTB unchanged and never allocates.
  - bp_branch_cnt += 1; bp_mispred_cnt += 1 on mispredict. Both wrap modulo 2^32.
- When agex_valid=0 or agex_is_branch=0: no state change and flush=0.

## Timing
- Reset state:
  - all BTB valid bits 0.
  - all PHT counters 2'b01 (weakly not-taken).
  - ghr 0; both counters 0.
- Reset outputs: flush=0, next_pc = fe_pc + 4.
- Prediction latency is 0 cycles: next_pc is valid in the same cycle as fe_pc.
- Flush:
  - combinational in the resolution cycle; high exactly one cycle per mispredict.
  - the fetch stage loads next_pc and bubbles its latch on the same edge.
- Table writes take effect at the edge ending the resolution cycle. A lookup of the same entry in that cycle sees the old contents.
- Fetch stall has no effect here: lookups are pure functions of fe_pc and current state.
- A resolution coincident with reset is ignored; reset wins.
- No backpressure and no handshake. One resolution per cycle maximum.

## Test plan
- Reset, fe_pc=0x100 -> {0, 0x104}; counters 0.
- AGEX taken branch at pc 0x120, target 0x200, pred_npc 0x124 -> flush=1, next_pc=0x200 that cycle; bp_mispred_cnt=1. Next cycle with fe_pc=0x120: counter is 2 and the BTB hits (provided ghr-derived index matches) -> next_pc=0x200, flush=0.
- Same branch taken 4 times with ghr forced constant via repeated outcome -> counter saturates at 3. Then 1 not-taken -> counter 2, still predicts 0x200.
- Not-taken branch with pred_npc=pc+4 -> flush=0, BTB not allocated, bp_branch_cnt increments, mispred count unchanged.
- BTB alias: taken at 0x100 (target 0x300), then taken at 0x140 (same index, target 0x400) -> lookup at 0x100 misses and returns 0x104.
- agex_valid=0 with agex_is_branch=1 and mismatched pred_npc -> flush=0, no state change. Reset asserted mid-run -> the next cycle satisfies the reset state.
